// File: rtl/seqgen_pkg.sv
// Shared types and pin field positions for the serial test-pattern generator.
package seqgen_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam int UI_START   = 0;
  localparam int UI_ABORT   = 1;
  localparam int UI_LEN_LSB = 2;
  localparam int UI_LEN_MSB = 4;
  localparam int UI_CNT_LSB = 5;
  localparam int UI_CNT_MSB = 7;

  localparam int UO_SERIAL  = 0;
  localparam int UO_VALID   = 1;
  localparam int UO_BUSY    = 2;
  localparam int UO_DONE    = 3;
  localparam int UO_IDX_LSB = 4;
  localparam int UO_IDX_MSB = 6;
  localparam int UO_LAST    = 7;

  typedef struct packed {
    logic       last_frame;
    logic [2:0] bit_idx;
    logic       done;
    logic       busy;
    logic       bit_valid;
    logic       serial;
  } seq_out_t;

  localparam seq_out_t OUT_IDLE = '0;

  function automatic seq_out_t mk_out(input logic serial, input logic bit_valid,
                                      input logic busy, input logic done,
                                      input logic [2:0] bit_idx, input logic last_frame);
    seq_out_t o;
    o.serial     = serial;
    o.bit_valid  = bit_valid;
    o.busy       = busy;
    o.done       = done;
    o.bit_idx    = bit_idx;
    o.last_frame = last_frame;
    return o;
  endfunction

endpackage

// File: rtl/seqgen_core.sv
// FSM, shift register and frame/gap counters; all outputs registered.
module seqgen_core
  import seqgen_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] len_m1,
  input  logic [2:0] cnt_m1,
  input  logic [7:0] pattern,
  output seq_out_t   outs
);

  state_t     state;
  logic       start_q;
  logic [7:0] shreg;
  logic [7:0] pat;
  logic [2:0] len_q;
  logic [2:0] rem;
  logic [3:0] gap_cnt;
  logic       start_edge;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      shreg   <= '0;
      pat     <= '0;
      len_q   <= '0;
      rem     <= '0;
      gap_cnt <= '0;
      outs    <= OUT_IDLE;
    end else if (ena) begin
      start_q <= start;
      case (state)
        IDLE: begin
          outs <= OUT_IDLE;
          if (start_edge && !abort) begin
            shreg <= pattern;
            pat   <= pattern;
            len_q <= len_m1;
            rem   <= cnt_m1;
            state <= SHIFT;
            outs  <= mk_out(pattern[7], 1'b1, 1'b1, 1'b0, 3'd0, cnt_m1 == 3'd0);
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            outs  <= OUT_IDLE;
          end else if (outs.bit_idx == len_q) begin
            if (rem != 3'd0) begin
              rem   <= rem - 3'd1;
              shreg <= pat;
              if (GAP_CYCLES == 0) begin
                outs <= mk_out(pat[7], 1'b1, 1'b1, 1'b0, 3'd0, rem == 3'd1);
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
                outs    <= mk_out(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
              end
            end else begin
              state <= DONE;
              outs  <= mk_out(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
            end
          end else begin
            shreg <= {shreg[6:0], 1'b0};
            outs  <= mk_out(shreg[6], 1'b1, 1'b1, 1'b0, outs.bit_idx + 3'd1, outs.last_frame);
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
            outs  <= OUT_IDLE;
          end else if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            state <= SHIFT;
            outs  <= mk_out(shreg[7], 1'b1, 1'b1, 1'b0, 3'd0, rem == 3'd0);
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          outs  <= OUT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/tt_um_prampal_seqgen.sv
// Tiny Tapeout pin wrapper around seqgen_core; uio pins are inputs only.
module tt_um_prampal_seqgen
  import seqgen_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  seq_out_t outs;

  seqgen_core #(.GAP_CYCLES(GAP_CYCLES)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (ui_in[UI_START]),
    .abort   (ui_in[UI_ABORT]),
    .len_m1  (ui_in[UI_LEN_MSB:UI_LEN_LSB]),
    .cnt_m1  (ui_in[UI_CNT_MSB:UI_CNT_LSB]),
    .pattern (uio_in),
    .outs    (outs)
  );

  always_comb begin
    uo_out                        = '0;
    uo_out[UO_SERIAL]             = outs.serial;
    uo_out[UO_VALID]              = outs.bit_valid;
    uo_out[UO_BUSY]               = outs.busy;
    uo_out[UO_DONE]               = outs.done;
    uo_out[UO_IDX_MSB:UO_IDX_LSB] = outs.bit_idx;
    uo_out[UO_LAST]               = outs.last_frame;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
